// File: rtl/udma_tx_dp_arbiter.sv
// uDMA Tx data-plane arbiter: round-robin share of one L2 read port among N_CH channels, with an
// ID FIFO that routes aligned read data back. Define UDMA_TX_DP_ARB_PRIO_EN to add ch_prio_i classes.
module udma_tx_dp_arbiter #(
   parameter int unsigned N_CH    = 4,
   parameter int unsigned ADDR_W  = 32,
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned MAX_OUT = 2
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [N_CH-1:0]        ch_req_i,
   input  logic [N_CH*ADDR_W-1:0] ch_addr_i,
   input  logic [N_CH*2-1:0]      ch_size_i,
`ifdef UDMA_TX_DP_ARB_PRIO_EN
   input  logic [N_CH-1:0]        ch_prio_i,
`endif
   output logic [N_CH-1:0]        ch_gnt_o,
   output logic [N_CH-1:0]        ch_rvalid_o,
   output logic [DATA_W-1:0]      ch_rdata_o,
   output logic                   l2_req_o,
   output logic [ADDR_W-1:0]      l2_addr_o,
   input  logic                   l2_gnt_i,
   input  logic                   l2_rvalid_i,
   input  logic [DATA_W-1:0]      l2_rdata_i,
   output logic                   busy_o,
   output logic                   err_o
);
   localparam int unsigned SEL_W = $clog2(N_CH);
   localparam int unsigned CNT_W = $clog2(MAX_OUT + 1);
   localparam int unsigned IDX_W = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
   localparam int unsigned DEPTH = 2 ** IDX_W;

   typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_e;
   state_e state_q, state_d;

   logic [SEL_W-1:0]  ptr_q, ptr_d;
   logic [SEL_W-1:0]  sel_q;
   logic [ADDR_W-1:0] addr_q;
   logic [1:0]        size_q;
   logic [CNT_W-1:0]  count_q, count_d;
   logic [IDX_W-1:0]  wr_q, wr_d, rd_q, rd_d;
   logic              err_q, err_d;
   logic [N_CH-1:0]   rvalid_q, rvalid_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic [SEL_W-1:0]  fifo_sel_q  [DEPTH];
   logic [1:0]        fifo_off_q  [DEPTH];
   logic [1:0]        fifo_size_q [DEPTH];

   logic [N_CH-1:0]   cand;
   logic              win_vld;
   logic [SEL_W-1:0]  win_sel, idx;
   logic              can_issue, push, pop;
   logic [SEL_W-1:0]  cur_sel;
   logic [ADDR_W-1:0] cur_addr;
   logic [1:0]        cur_size, hd_off, hd_size;
   logic [DATA_W-1:0] shifted, mask;

   assign can_issue = 32'(count_q) < MAX_OUT;
   assign push      = l2_req_o & l2_gnt_i;
   assign pop       = l2_rvalid_i & (count_q != '0);

   // First requester at or after the pointer, within the winning priority class
   always_comb begin
      cand = ch_req_i;
`ifdef UDMA_TX_DP_ARB_PRIO_EN
      if (|(ch_req_i & ch_prio_i)) cand = ch_req_i & ch_prio_i;
`endif
      win_vld = 1'b0;
      win_sel = '0;
      idx     = '0;
      for (int unsigned i = 0; i < N_CH; i++) begin
         idx = SEL_W'((32'(ptr_q) + i) % N_CH);
         if (!win_vld && cand[idx]) begin
            win_vld = 1'b1;
            win_sel = idx;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (l2_req_o && !l2_gnt_i) state_d = LOCKED;
         LOCKED:  if (l2_gnt_i) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Presented request: held registers while locked, live winner otherwise
   always_comb begin
      l2_req_o = 1'b0;
      cur_sel  = '0;
      cur_addr = '0;
      cur_size = '0;
      ch_gnt_o = '0;
      if (!reset) begin
         if (state_q == LOCKED) begin
            l2_req_o = 1'b1;
            cur_sel  = sel_q;
            cur_addr = addr_q;
            cur_size = size_q;
         end else if (win_vld && can_issue) begin
            l2_req_o = 1'b1;
            cur_sel  = win_sel;
            cur_addr = ch_addr_i[32'(win_sel)*ADDR_W +: ADDR_W];
            cur_size = ch_size_i[32'(win_sel)*2 +: 2];
         end
      end
      if (l2_req_o && l2_gnt_i) ch_gnt_o[cur_sel] = 1'b1;
   end

   assign l2_addr_o   = {cur_addr[ADDR_W-1:2], 2'b00};
   assign busy_o      = (state_q == LOCKED) | l2_req_o | (count_q != '0);
   assign ch_rvalid_o = rvalid_q;
   assign ch_rdata_o  = rdata_q;
   assign err_o       = err_q;

   always_comb begin
      ptr_d    = ptr_q;
      wr_d     = wr_q;
      rd_d     = rd_q;
      err_d    = err_q;
      rvalid_d = '0;
      rdata_d  = rdata_q;
      hd_off   = fifo_off_q[rd_q];
      hd_size  = fifo_size_q[rd_q];
      shifted  = l2_rdata_i >> {hd_off, 3'b000};
      case (hd_size)
         2'd0:    mask = DATA_W'(8'hFF);
         2'd1:    mask = DATA_W'(16'hFFFF);
         default: mask = '1;
      endcase
      if (push) begin
         ptr_d = (32'(cur_sel) == N_CH - 1) ? '0 : cur_sel + SEL_W'(1);
         wr_d  = (32'(wr_q) == MAX_OUT - 1) ? '0 : wr_q + IDX_W'(1);
      end
      if (pop) begin
         rvalid_d[fifo_sel_q[rd_q]] = 1'b1;
         rdata_d = shifted & mask;
         rd_d    = (32'(rd_q) == MAX_OUT - 1) ? '0 : rd_q + IDX_W'(1);
      end
      if (l2_rvalid_i && count_q == '0) err_d = 1'b1;
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ptr_q    <= '0;
         sel_q    <= '0;
         addr_q   <= '0;
         size_q   <= '0;
         count_q  <= '0;
         wr_q     <= '0;
         rd_q     <= '0;
         err_q    <= 1'b0;
         rvalid_q <= '0;
         rdata_q  <= '0;
         for (int unsigned i = 0; i < DEPTH; i++) begin
            fifo_sel_q[i]  <= '0;
            fifo_off_q[i]  <= '0;
            fifo_size_q[i] <= '0;
         end
      end else begin
         ptr_q    <= ptr_d;
         count_q  <= count_d;
         wr_q     <= wr_d;
         rd_q     <= rd_d;
         err_q    <= err_d;
         rvalid_q <= rvalid_d;
         rdata_q  <= rdata_d;
         if (state_q == IDLE && l2_req_o && !l2_gnt_i) begin
            sel_q  <= cur_sel;
            addr_q <= cur_addr;
            size_q <= cur_size;
         end
         if (push) begin
            fifo_sel_q[wr_q]  <= cur_sel;
            fifo_off_q[wr_q]  <= cur_addr[1:0];
            fifo_size_q[wr_q] <= cur_size;
         end
      end
   end
endmodule

// File: tb/tb_udma_tx_dp_arbiter.sv
// Self-checking bench for udma_tx_dp_arbiter: directed scenarios plus a randomized run
// against a queue-based reference model.
module tb_udma_tx_dp_arbiter;
   localparam int N_CH    = 4;
   localparam int ADDR_W  = 32;
   localparam int DATA_W  = 32;
   localparam int MAX_OUT = 2;

   logic                   clk = 1'b0;
   logic                   reset;
   logic [N_CH-1:0]        ch_req;
   logic [N_CH*ADDR_W-1:0] ch_addr;
   logic [N_CH*2-1:0]      ch_size;
   logic                   l2_gnt, l2_rvalid;
   logic [DATA_W-1:0]      l2_rdata;
   logic [N_CH-1:0]        ch_gnt_o, ch_rvalid_o;
   logic [DATA_W-1:0]      ch_rdata_o;
   logic                   l2_req_o, busy_o, err_o;
   logic [ADDR_W-1:0]      l2_addr_o;

   int vectors = 0;
   int errors  = 0;

   udma_tx_dp_arbiter #(.N_CH(N_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_OUT(MAX_OUT)) dut (
      .clk(clk), .reset(reset), .ch_req_i(ch_req), .ch_addr_i(ch_addr), .ch_size_i(ch_size),
`ifdef UDMA_TX_DP_ARB_PRIO_EN
      .ch_prio_i('0),
`endif
      .ch_gnt_o(ch_gnt_o), .ch_rvalid_o(ch_rvalid_o), .ch_rdata_o(ch_rdata_o),
      .l2_req_o(l2_req_o), .l2_addr_o(l2_addr_o), .l2_gnt_i(l2_gnt), .l2_rvalid_i(l2_rvalid),
      .l2_rdata_i(l2_rdata), .busy_o(busy_o), .err_o(err_o));

   always #5 clk = ~clk;

   // Reference model: outstanding reads as a queue, lock as a held record
   typedef struct { int ch; int off; int sz; } ent_t;
   ent_t              m_q[$];
   int                m_ptr, m_ch, m_size;
   bit                m_lk, m_err;
   logic [ADDR_W-1:0] m_addr;
   logic [N_CH-1:0]   m_rv;
   logic [DATA_W-1:0] m_rdata;
   bit                e_req, e_busy;
   int                e_ch, e_size;
   logic [ADDR_W-1:0] e_addr;
   logic [N_CH-1:0]   e_gnt;

   function automatic logic [31:0] align_ref(logic [31:0] d, int off, int sz);
      logic [31:0] r;
      r = '0;
      for (int b = 0; b < (1 << sz); b++)
         if (off + b < 4) r[8*b +: 8] = d[8*(off+b) +: 8];
      return r;
   endfunction

   task automatic model_reset();
      m_q.delete();
      m_ptr = 0; m_lk = 0; m_err = 0; m_rv = '0; m_rdata = '0;
      m_ch = 0; m_addr = '0; m_size = 0;
   endtask

   task automatic model_comb();
      e_req = 0; e_ch = 0; e_addr = '0; e_size = 0;
      if (m_lk) begin
         e_req = 1; e_ch = m_ch; e_addr = m_addr; e_size = m_size;
      end else if (m_q.size() < MAX_OUT) begin
         for (int k = 0; k < N_CH; k++) begin
            int c;
            c = (m_ptr + k) % N_CH;
            if (!e_req && ch_req[c]) begin
               e_req = 1; e_ch = c;
               e_addr = ch_addr[c*ADDR_W +: ADDR_W];
               e_size = int'(ch_size[c*2 +: 2]);
            end
         end
      end
      e_gnt  = (e_req && l2_gnt) ? (N_CH'(1) << e_ch) : '0;
      e_busy = m_lk || e_req || (m_q.size() != 0);
   endtask

   task automatic model_clk();
      ent_t e;
      m_rv = '0;
      if (l2_rvalid) begin
         if (m_q.size() != 0) begin
            e = m_q.pop_front();
            m_rv = N_CH'(1) << e.ch;
            m_rdata = align_ref(l2_rdata, e.off, e.sz);
         end else m_err = 1;
      end
      if (e_req && l2_gnt) begin
         e.ch = e_ch; e.off = int'(e_addr[1:0]); e.sz = e_size;
         m_q.push_back(e);
         m_ptr = (e_ch + 1) % N_CH;
         m_lk = 0;
      end else if (e_req) begin
         m_lk = 1; m_ch = e_ch; m_addr = e_addr; m_size = e_size;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_reset();
      reset = 1; ch_req = '0; ch_addr = '0; ch_size = '0;
      l2_gnt = 0; l2_rvalid = 0; l2_rdata = '0;
      model_reset();
      @(negedge clk); @(negedge clk);
      reset = 0;
   endtask

   task automatic test_reset();
      reset = 1; ch_req = '1; l2_gnt = 1; l2_rvalid = 1; l2_rdata = 32'h1234_5678;
      #1;
      vectors++;
      if ({l2_req_o, busy_o, err_o, ch_gnt_o, ch_rvalid_o, l2_addr_o} !== '0) begin
         errors++; $display("FAIL reset_outputs: got req=%b busy=%b err=%b gnt=%b rv=%b addr=%h, expected all 0",
                            l2_req_o, busy_o, err_o, ch_gnt_o, ch_rvalid_o, l2_addr_o);
      end
      tick();
      vectors++;
      if ({l2_req_o, busy_o, err_o, ch_rvalid_o} !== '0) begin
         errors++; $display("FAIL reset_held: got req=%b busy=%b err=%b rv=%b, expected 0", l2_req_o, busy_o, err_o, ch_rvalid_o);
      end
      do_reset();
      #1;
      vectors++;
      if ({l2_req_o, busy_o, err_o, ch_rvalid_o} !== '0) begin
         errors++; $display("FAIL reset_release_idle: got req=%b busy=%b err=%b rv=%b, expected 0", l2_req_o, busy_o, err_o, ch_rvalid_o);
      end
   endtask

   task automatic test_rr_order();
      logic [N_CH-1:0]   exp_g, exp_v;
      logic [DATA_W-1:0] prev;
      do_reset();
      ch_req = '1; l2_gnt = 1;
      for (int k = 0; k < 6; k++) begin
         prev = l2_rdata;
         l2_rvalid = (k > 0);
         l2_rdata = $urandom;
         #1;
         exp_g = N_CH'(1) << (k % N_CH);
         vectors++;
         if (ch_gnt_o !== exp_g) begin
            errors++; $display("FAIL rr_grant[%0d]: got %b, expected %b", k, ch_gnt_o, exp_g);
         end
         exp_v = (k >= 2) ? (N_CH'(1) << ((k - 2) % N_CH)) : '0;
         vectors++;
         if (ch_rvalid_o !== exp_v) begin
            errors++; $display("FAIL rr_rvalid[%0d]: got %b, expected %b", k, ch_rvalid_o, exp_v);
         end
         if (k >= 2) begin
            vectors++;
            if (ch_rdata_o !== {24'h0, prev[7:0]}) begin
               errors++; $display("FAIL rr_rdata[%0d]: got %h, expected %h", k, ch_rdata_o, {24'h0, prev[7:0]});
            end
         end
         tick();
      end
   endtask

   task automatic test_align();
      int c, sz;
      logic [31:0] a, d, exp_d;
      do_reset();
      ch_req = 4'b0010; ch_addr[1*ADDR_W +: ADDR_W] = 32'h1003; ch_size[2 +: 2] = 2'd0; l2_gnt = 1;
      #1;
      vectors++;
      if (l2_addr_o !== 32'h1000 || ch_gnt_o !== 4'b0010) begin
         errors++; $display("FAIL align_addr: got addr=%h gnt=%b, expected 00001000 0010", l2_addr_o, ch_gnt_o);
      end
      tick();
      ch_req = '0; l2_gnt = 0; l2_rvalid = 1; l2_rdata = 32'hAABBCCDD;
      tick();
      l2_rvalid = 0;
      #1;
      vectors++;
      if (ch_rvalid_o !== 4'b0010 || ch_rdata_o !== 32'h0000_00AA) begin
         errors++; $display("FAIL align_byte3: got rv=%b data=%h, expected 0010 000000aa", ch_rvalid_o, ch_rdata_o);
      end
      for (int i = 0; i < 12; i++) begin
         c = $urandom_range(0, N_CH - 1); a = $urandom; sz = $urandom_range(0, 2); d = $urandom;
         ch_req = N_CH'(1) << c; ch_addr[c*ADDR_W +: ADDR_W] = a; ch_size[c*2 +: 2] = 2'(sz); l2_gnt = 1;
         #1;
         vectors++;
         if (l2_addr_o !== {a[31:2], 2'b00}) begin
            errors++; $display("FAIL align_l2addr[%0d]: got %h, expected %h", i, l2_addr_o, {a[31:2], 2'b00});
         end
         tick();
         ch_req = '0; l2_gnt = 0; l2_rvalid = 1; l2_rdata = d;
         tick();
         l2_rvalid = 0;
         #1;
         exp_d = align_ref(d, int'(a[1:0]), sz);
         vectors++;
         if (ch_rvalid_o !== (N_CH'(1) << c) || ch_rdata_o !== exp_d) begin
            errors++; $display("FAIL align_data[%0d]: got rv=%b data=%h, expected rv=%b data=%h (off=%0d sz=%0d)",
                               i, ch_rvalid_o, ch_rdata_o, N_CH'(1) << c, exp_d, a[1:0], sz);
         end
         tick();
      end
   endtask

   task automatic test_lock();
      do_reset();
      ch_req = 4'b0001; ch_addr[0 +: ADDR_W] = 32'h2006; ch_addr[3*ADDR_W +: ADDR_W] = 32'h3008; l2_gnt = 0;
      #1;
      vectors++;
      if (l2_req_o !== 1'b1 || l2_addr_o !== 32'h2004) begin
         errors++; $display("FAIL lock_first: got req=%b addr=%h, expected 1 00002004", l2_req_o, l2_addr_o);
      end
      tick();
      ch_req = 4'b1000; ch_addr[0 +: ADDR_W] = 32'hDEAD_0000;
      for (int i = 0; i < 5; i++) begin
         #1;
         vectors++;
         if (l2_req_o !== 1'b1 || l2_addr_o !== 32'h2004 || ch_gnt_o !== '0 || busy_o !== 1'b1) begin
            errors++; $display("FAIL lock_hold[%0d]: got req=%b addr=%h gnt=%b busy=%b, expected 1 00002004 0000 1",
                               i, l2_req_o, l2_addr_o, ch_gnt_o, busy_o);
         end
         tick();
      end
      l2_gnt = 1;
      #1;
      vectors++;
      if (ch_gnt_o !== 4'b0001 || l2_addr_o !== 32'h2004) begin
         errors++; $display("FAIL lock_grant: got gnt=%b addr=%h, expected 0001 00002004", ch_gnt_o, l2_addr_o);
      end
      tick();
      #1;
      vectors++;
      if (ch_gnt_o !== 4'b1000 || l2_addr_o !== 32'h3008) begin
         errors++; $display("FAIL lock_next: got gnt=%b addr=%h, expected 1000 00003008", ch_gnt_o, l2_addr_o);
      end
      tick();
   endtask

   task automatic test_max_out();
      do_reset();
      ch_req = '1; l2_gnt = 1;
      #1;
      vectors++;
      if (ch_gnt_o !== 4'b0001) begin
         errors++; $display("FAIL maxout_g0: got %b, expected 0001", ch_gnt_o);
      end
      tick(); #1;
      vectors++;
      if (ch_gnt_o !== 4'b0010) begin
         errors++; $display("FAIL maxout_g1: got %b, expected 0010", ch_gnt_o);
      end
      tick(); #1;
      vectors++;
      if (l2_req_o !== 1'b0 || ch_gnt_o !== '0 || busy_o !== 1'b1) begin
         errors++; $display("FAIL maxout_full: got req=%b gnt=%b busy=%b, expected 0 0000 1", l2_req_o, ch_gnt_o, busy_o);
      end
      tick();
      l2_rvalid = 1; l2_rdata = 32'h0000_0055;
      #1;
      vectors++;
      if (l2_req_o !== 1'b0) begin
         errors++; $display("FAIL maxout_pop_cycle: got req=%b, expected 0", l2_req_o);
      end
      tick();
      l2_rvalid = 0;
      #1;
      vectors++;
      if (l2_req_o !== 1'b1 || ch_gnt_o !== 4'b0100 || ch_rvalid_o !== 4'b0001) begin
         errors++; $display("FAIL maxout_resume: got req=%b gnt=%b rv=%b, expected 1 0100 0001", l2_req_o, ch_gnt_o, ch_rvalid_o);
      end
      tick();
   endtask

   task automatic test_err();
      do_reset();
      l2_rvalid = 1; l2_rdata = 32'hFFFF_FFFF;
      #1;
      vectors++;
      if (err_o !== 1'b0) begin
         errors++; $display("FAIL err_before: got %b, expected 0", err_o);
      end
      tick();
      l2_rvalid = 0;
      for (int i = 0; i < 4; i++) begin
         #1;
         vectors++;
         if (err_o !== 1'b1 || ch_rvalid_o !== '0) begin
            errors++; $display("FAIL err_sticky[%0d]: got err=%b rv=%b, expected 1 0000", i, err_o, ch_rvalid_o);
         end
         tick();
      end
      reset = 1;
      #1;
      vectors++;
      if (err_o !== 1'b0) begin
         errors++; $display("FAIL err_cleared: got %b, expected 0", err_o);
      end
   endtask

   task automatic test_reset_locked();
      do_reset();
      ch_req = 4'b0001; l2_gnt = 1;
      tick();
      ch_req = 4'b0010; ch_addr[1*ADDR_W +: ADDR_W] = 32'h40; l2_gnt = 0;
      tick();
      #1;
      vectors++;
      if (l2_req_o !== 1'b1 || l2_addr_o !== 32'h40 || busy_o !== 1'b1) begin
         errors++; $display("FAIL rstlk_locked: got req=%b addr=%h busy=%b, expected 1 00000040 1", l2_req_o, l2_addr_o, busy_o);
      end
      reset = 1;
      #1;
      vectors++;
      if ({l2_req_o, busy_o, err_o, ch_gnt_o, ch_rvalid_o, l2_addr_o} !== '0) begin
         errors++; $display("FAIL rstlk_zero: got req=%b busy=%b err=%b gnt=%b rv=%b addr=%h, expected all 0",
                            l2_req_o, busy_o, err_o, ch_gnt_o, ch_rvalid_o, l2_addr_o);
      end
      tick();
      reset = 0; ch_req = '0; l2_rvalid = 1;
      tick();
      l2_rvalid = 0;
      #1;
      vectors++;
      if (err_o !== 1'b1 || ch_rvalid_o !== '0 || busy_o !== 1'b0) begin
         errors++; $display("FAIL rstlk_late_rvalid: got err=%b rv=%b busy=%b, expected 1 0000 0", err_o, ch_rvalid_o, busy_o);
      end
   endtask

   task automatic test_random();
      do_reset();
      for (int cyc = 0; cyc < 600; cyc++) begin
         ch_req = N_CH'($urandom_range(0, (1 << N_CH) - 1));
         for (int c = 0; c < N_CH; c++) begin
            ch_addr[c*ADDR_W +: ADDR_W] = $urandom;
            ch_size[c*2 +: 2] = 2'($urandom_range(0, 2));
         end
         l2_gnt    = ($urandom_range(0, 3) != 0);
         l2_rvalid = (m_q.size() != 0) ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 39) == 0);
         l2_rdata  = $urandom;
         #1;
         model_comb();
         vectors++;
         if (l2_req_o !== e_req || (e_req && l2_addr_o !== {e_addr[ADDR_W-1:2], 2'b00})) begin
            errors++; $display("FAIL rand_req[%0d]: got req=%b addr=%h, expected req=%b addr=%h",
                               cyc, l2_req_o, l2_addr_o, e_req, {e_addr[ADDR_W-1:2], 2'b00});
         end
         vectors++;
         if (ch_gnt_o !== e_gnt || busy_o !== e_busy) begin
            errors++; $display("FAIL rand_gnt[%0d]: got gnt=%b busy=%b, expected gnt=%b busy=%b", cyc, ch_gnt_o, busy_o, e_gnt, e_busy);
         end
         vectors++;
         if (ch_rvalid_o !== m_rv || (m_rv != '0 && ch_rdata_o !== m_rdata) || err_o !== m_err) begin
            errors++; $display("FAIL rand_resp[%0d]: got rv=%b data=%h err=%b, expected rv=%b data=%h err=%b",
                               cyc, ch_rvalid_o, ch_rdata_o, err_o, m_rv, m_rdata, m_err);
         end
         model_clk();
         tick();
      end
   endtask

   initial begin
      reset = 1; ch_req = '0; ch_addr = '0; ch_size = '0;
      l2_gnt = 0; l2_rvalid = 0; l2_rdata = '0;
      @(negedge clk);
      test_reset();
      test_rr_order();
      test_align();
      test_lock();
      test_max_out();
      test_err();
      test_reset_locked();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end
endmodule
